// File: rtl/mem_skew_control.sv
// rtl/mem_skew_control.sv - per-lane wavefront skew of read address/enable and done re-timing
// Lane k is delayed k+1 cycles; the done edge travels a width_height-stage chain.
module mem_skew_control #(
    parameter int addr_width   = 8,
    parameter int width_height = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [addr_width*width_height-1:0]   in_addr,
    input  logic [width_height-1:0]              in_en,
    input  logic                                 in_done,
    output logic [addr_width*width_height-1:0]   out_addr,
    output logic [width_height-1:0]              out_en,
    output logic                                 out_done,
    output logic                                 busy
);

    logic [width_height-1:0] w_lane_busy;
    logic [width_height-1:0] r_done_chain;
    logic [width_height-1:0] w_done_next;
    logic                    r_in_done_q;
    logic                    w_done_evt;
    logic                    r_busy;

    genvar k;
    generate
        for (k = 0; k < width_height; k++) begin : g_lane
            logic [k:0]            r_en;
            logic [addr_width-1:0] r_addr      [0:k];
            logic [k:0]            w_en_next;
            logic [addr_width-1:0] w_addr_next [0:k];

            // Disabled rows store a zero address so nothing stale reaches the buffer.
            always_comb begin
                w_en_next[0]   = in_en[k];
                w_addr_next[0] = in_en[k] ? in_addr[k*addr_width +: addr_width] : '0;
                for (int j = 1; j <= k; j++) begin
                    w_en_next[j]   = r_en[j-1];
                    w_addr_next[j] = r_addr[j-1];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_en <= '0;
                    for (int j = 0; j <= k; j++) begin
                        r_addr[j] <= '0;
                    end
                end else begin
                    r_en <= w_en_next;
                    for (int j = 0; j <= k; j++) begin
                        r_addr[j] <= w_addr_next[j];
                    end
                end
            end

            assign w_lane_busy[k]                       = |w_en_next;
            assign out_en[k]                            = r_en[k];
            assign out_addr[k*addr_width +: addr_width] = r_addr[k];
        end
    endgenerate

    assign w_done_evt  = in_done & ~r_in_done_q;
    assign w_done_next = {r_done_chain[width_height-2:0], w_done_evt};

    // in_done_q tracks in_done even in reset so a level held across release is not an edge.
    always_ff @(posedge clk) begin
        r_in_done_q <= in_done;
        if (reset) begin
            r_done_chain <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_done_chain <= w_done_next;
            r_busy       <= (|w_lane_busy) | (|w_done_next);
        end
    end

    assign out_done = r_done_chain[width_height-1];
    assign busy     = r_busy;

endmodule

// File: tb/tb_mem_skew_control.sv
// tb/tb_mem_skew_control.sv - directed vector table plus done-edge sequence for mem_skew_control
module tb_mem_skew_control;

    localparam int AW = 8;
    localparam int WH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [AW*WH-1:0]  in_addr;
    logic [WH-1:0]     in_en;
    logic              in_done;
    logic [AW*WH-1:0]  out_addr;
    logic [WH-1:0]     out_en;
    logic              out_done;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic             rst;
        logic [AW*WH-1:0] addr;
        logic [WH-1:0]    en;
        logic             done;
        logic [AW*WH-1:0] e_addr;
        logic [WH-1:0]    e_en;
        logic             e_done;
        logic             e_busy;
    } vec_t;

    vec_t vecs[$];

    mem_skew_control #(.addr_width(AW), .width_height(WH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_addr  (in_addr),
        .in_en    (in_en),
        .in_done  (in_done),
        .out_addr (out_addr),
        .out_en   (out_en),
        .out_done (out_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic [31:0] addr, input logic [3:0] en,
                       input logic done, input logic [31:0] e_addr, input logic [3:0] e_en,
                       input logic e_done, input logic e_busy);
        vec_t v;
        v.rst = rst; v.addr = addr; v.en = en; v.done = done;
        v.e_addr = e_addr; v.e_en = e_en; v.e_done = e_done; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        int first;
        reset = 1'b1; in_addr = '0; in_en = '0; in_done = 1'b0;

        // reset with junk inputs
        add(1, 32'hDEADBEEF, 4'hF, 1, 32'h0, 4'h0, 0, 0);
        add(1, 32'h5A5A1234, 4'h9, 0, 32'h0, 4'h0, 0, 0);
        add(1, 32'hCAFEF00D, 4'h6, 1, 32'h0, 4'h0, 0, 0);
        add(0, 32'h0,        4'h0, 0, 32'h0, 4'h0, 0, 0);
        // single vector
        add(0, 32'h10101010, 4'hF, 0, 32'h00000010, 4'b0001, 0, 1);
        add(0, 32'h0,        4'h0, 0, 32'h00001000, 4'b0010, 0, 1);
        add(0, 32'h0,        4'h0, 0, 32'h00100000, 4'b0100, 0, 1);
        add(0, 32'h0,        4'h0, 0, 32'h10000000, 4'b1000, 0, 1);
        add(0, 32'h0,        4'h0, 0, 32'h0,        4'b0000, 0, 0);
        // streaming pass, lanes 2/3 disabled must stay zero
        add(0, 32'h20202020, 4'h3, 0, 32'h00000020, 4'b0001, 0, 1);
        add(0, 32'h21212121, 4'h3, 0, 32'h00002021, 4'b0011, 0, 1);
        add(0, 32'h22222222, 4'h3, 0, 32'h00002122, 4'b0011, 0, 1);
        add(0, 32'h23232323, 4'h3, 0, 32'h00002223, 4'b0011, 0, 1);
        add(0, 32'h0,        4'h0, 1, 32'h00002300, 4'b0010, 0, 1);
        add(0, 32'h0,        4'h0, 1, 32'h0,        4'b0000, 0, 1);
        add(0, 32'h0,        4'h0, 1, 32'h0,        4'b0000, 0, 1);
        add(0, 32'h0,        4'h0, 1, 32'h0,        4'b0000, 1, 1);
        add(0, 32'h0,        4'h0, 0, 32'h0,        4'b0000, 0, 0);
        // held done: one pulse, then fall/rise gives another
        for (int i = 0; i < 10; i++)
            add(0, 32'h0, 4'h0, 1, 32'h0, 4'h0, (i == 3), (i <= 3));
        add(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 32'h0, 4'h0, 1, 32'h0, 4'h0, (i == 3), 1);
        add(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 0, 0);
        // overlapping done edges stay separate
        add(0, 32'h0, 4'h0, 1, 32'h0, 4'h0, 0, 1);
        add(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 0, 1);
        add(0, 32'h0, 4'h0, 1, 32'h0, 4'h0, 0, 1);
        add(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1, 1);
        add(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 0, 1);
        add(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 1, 1);
        add(0, 32'h0, 4'h0, 0, 32'h0, 4'h0, 0, 0);
        // back-to-back vectors with a simultaneous done edge
        add(0, 32'hA0A0A0A0, 4'hF, 1, 32'h000000A0, 4'b0001, 0, 1);
        add(0, 32'hB0B0B0B0, 4'hF, 1, 32'h0000A0B0, 4'b0011, 0, 1);
        add(0, 32'h0,        4'h0, 1, 32'h00A0B000, 4'b0110, 0, 1);
        add(0, 32'h0,        4'h0, 1, 32'hA0B00000, 4'b1100, 1, 1);
        add(0, 32'h0,        4'h0, 1, 32'hB0000000, 4'b1000, 0, 1);
        add(0, 32'h0,        4'h0, 1, 32'h0,        4'b0000, 0, 0);
        // reset mid-flight, done held high across release
        add(0, 32'h0,        4'h0, 0, 32'h0,        4'b0000, 0, 0);
        add(0, 32'h10101010, 4'hF, 1, 32'h00000010, 4'b0001, 0, 1);
        add(0, 32'h0,        4'h0, 1, 32'h00001000, 4'b0010, 0, 1);
        add(1, 32'h0,        4'h0, 1, 32'h0,        4'b0000, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 32'h0, 4'h0, 1, 32'h0, 4'h0, 0, 0);

        foreach (vecs[i]) begin
            reset   = vecs[i].rst;
            in_addr = vecs[i].addr;
            in_en   = vecs[i].en;
            in_done = vecs[i].done;
            step();
            chk("out_en",   i, 32'(out_en),   32'(vecs[i].e_en));
            chk("out_addr", i, out_addr,      vecs[i].e_addr);
            chk("out_done", i, 32'(out_done), 32'(vecs[i].e_done));
            chk("busy",     i, 32'(busy),     32'(vecs[i].e_busy));
        end

        // after a reset-held level, fall then rise must yield one pulse 3 edges later
        in_done = 1'b0;
        step();
        in_done = 1'b1;
        step();
        pulses = 0;
        first  = -1;
        for (int c = 0; c < 8; c++) begin
            if (out_done) begin
                pulses++;
                if (first < 0) first = c;
            end
            step();
        end
        chk("post_reset_pulses", 0, 32'(pulses), 32'd1);
        chk("post_reset_pulse_pos", 0, 32'(first), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
